// File: rtl/switch_edge_detector.sv
`default_nettype none
// switch_edge_detector: synchronizes (and optionally debounces) a raw switch level
// and emits a one-cycle enable pulse on each qualifying edge of the accepted level.
module switch_edge_detector #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_MODE       = 0
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_enable,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   level_dly_q;
  logic                   enable_d;
  logic                   enable_q;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_sw};
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
    // Without a filter the final synchronizer flop is itself the accepted level.
    assign level = sync_q[SYNC_STAGES-1];
  end else begin : g_debounce
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q[SYNC_STAGES-1] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = sync_q[SYNC_STAGES-1];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign level = level_q;
  end

  always_comb begin
    enable_d = 1'b0;
    case (EDGE_MODE)
      1:       enable_d = ~level & level_dly_q;
      2:       enable_d = level ^ level_dly_q;
      default: enable_d = level & ~level_dly_q;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      level_dly_q <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      level_dly_q <= level;
      enable_q    <= enable_d;
    end
  end

  assign o_enable = enable_q;
  assign o_level  = level;

endmodule
`default_nettype wire

// File: tb/tb_switch_edge_detector.sv
`default_nettype none
`timescale 1ns/1ps
// Randomized scoreboard bench for switch_edge_detector over four parameter sets.
module tb_switch_edge_detector;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_sw;
  logic [3:0] en;
  logic [3:0] lvl;

  always #5 clk = ~clk;

  switch_edge_detector #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0)) u_d0 (
    .clk(clk), .i_rst(i_rst), .i_sw(i_sw), .o_enable(en[0]), .o_level(lvl[0]));
  switch_edge_detector #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2)) u_d1 (
    .clk(clk), .i_rst(i_rst), .i_sw(i_sw), .o_enable(en[1]), .o_level(lvl[1]));
  switch_edge_detector #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u_d2 (
    .clk(clk), .i_rst(i_rst), .i_sw(i_sw), .o_enable(en[2]), .o_level(lvl[2]));
  switch_edge_detector #(.SYNC_STAGES(4), .DEBOUNCE_CYCLES(2), .EDGE_MODE(1)) u_d3 (
    .clk(clk), .i_rst(i_rst), .i_sw(i_sw), .o_enable(en[3]), .o_level(lvl[3]));

  localparam int SS [4] = '{2, 3, 2, 4};
  localparam int NN [4] = '{0, 0, 4, 2};
  localparam int MM [4] = '{0, 2, 0, 1};
  localparam int HMAX = 8192;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] lvl;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pcnt [4] = '{0, 0, 0, 0};
  int   lastp[4] = '{0, 0, 0, 0};
  int   base [4];

  // Reference model: sampled input history since reset, accepted-level history per config.
  bit hist[HMAX];
  bit lh[4][HMAX];
  int hn = 0;

  function automatic bit xat(int n);
    return (n < 0) ? 1'b0 : hist[n];
  endfunction

  function automatic bit lat(int d, int n);
    return (n < 0) ? 1'b0 : lh[d][n];
  endfunction

  task automatic model_step();
    exp_t e;
    bit   prev, ln, all, l1, l2;
    e = '0;
    if (!i_rst) begin
      hn = 0;
    end else if (hn < HMAX) begin
      hist[hn] = i_sw;
      for (int d = 0; d < 4; d++) begin
        if (NN[d] == 0) begin
          ln = xat(hn - SS[d] + 1);
        end else begin
          // Accept the opposite level once the synchronized input showed it N cycles in a row.
          prev = lat(d, hn - 1);
          all  = 1'b1;
          for (int j = 1; j <= NN[d]; j++)
            if (xat(hn - j - SS[d] + 1) == prev) all = 1'b0;
          ln = all ? ~prev : prev;
        end
        lh[d][hn] = ln;
        l1 = lat(d, hn - 1);
        l2 = lat(d, hn - 2);
        case (MM[d])
          1:       e.en[d] = ~l1 & l2;
          2:       e.en[d] = l1 ^ l2;
          default: e.en[d] = l1 & ~l2;
        endcase
        e.lvl[d] = ln;
      end
      hn++;
    end
    expq.push_back(e);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      for (int d = 0; d < 4; d++) begin
        check_int($sformatf("enable[%0d] cyc%0d", d, cyc), int'(en[d]), int'(e.en[d]));
        check_int($sformatf("level[%0d] cyc%0d", d, cyc), int'(lvl[d]), int'(e.lvl[d]));
        if (en[d]) begin
          pcnt[d]++;
          lastp[d] = cyc;
        end
      end
    end
  end

  task automatic hold(input bit v, input int n);
    i_sw = v;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic snap();
    for (int d = 0; d < 4; d++) base[d] = pcnt[d];
  endtask

  initial begin
    int  got;
    bit  seen;
    i_rst = 1'b0;
    i_sw  = 1'b0;
    @(negedge clk);
    #1;
    hold(1'b0, 2);
    i_rst = 1'b1;
    hold(1'b0, 10);

    // Toggle every two cycles: 1,0,1,0,1 then stay high.
    snap();
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2);
    hold(1'b1, 16);
    check_int("toggle pulses rising", pcnt[0] - base[0], 3);
    check_int("toggle pulses both", pcnt[1] - base[1], 5);
    check_int("toggle pulses debounce4", pcnt[2] - base[2], 1);
    check_int("toggle pulses falling deb2", pcnt[3] - base[3], 2);
    hold(1'b0, 14);

    // Three-cycle glitch: filtered by the 4-cycle debounce only.
    snap();
    hold(1'b1, 3);
    hold(1'b0, 14);
    check_int("glitch debounce4 pulses", pcnt[2] - base[2], 0);
    check_int("glitch rising pulses", pcnt[0] - base[0], 1);

    // Level held 10 cycles: debounced pulse trails the plain one by 4 cycles.
    snap();
    hold(1'b1, 10);
    hold(1'b0, 14);
    check_int("hold10 debounce4 pulses", pcnt[2] - base[2], 1);
    check_int("debounce extra latency", lastp[2] - lastp[0], 4);

    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 59) == 0) begin
        i_rst = 1'b0;
        hold(i_sw, $urandom_range(1, 3));
        i_rst = 1'b1;
      end
      hold(1'(($urandom() >> 4) & 1), $urandom_range(1, 8));
    end

    // Asynchronous reset while a pulse is high.
    hold(1'b0, 14);
    i_sw = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (en[0]) seen = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    check_int("pulse seen before mid-pulse reset", int'(seen), 1);
    i_rst = 1'b0;
    #1;
    got = int'(en);
    check_int("enable drops in async reset", got, 0);
    check_int("level drops in async reset", int'(lvl), 0);
    hold(1'b1, 2);
    snap();
    i_rst = 1'b1;
    hold(1'b1, 14);
    check_int("post-reset pulses rising", pcnt[0] - base[0], 1);
    check_int("post-reset pulses both", pcnt[1] - base[1], 1);
    check_int("post-reset pulses debounce4", pcnt[2] - base[2], 1);
    check_int("post-reset pulses falling", pcnt[3] - base[3], 0);

    hold(1'b1, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/switch_edge_detector.md
# switch_edge_detector

Converts a slow, asynchronous switch/button level (`i_sw`) into a single-clock-cycle enable pulse (`o_enable`) on each qualifying edge. The input is synchronized and optionally debounced before edge detection. The block sits between board-level switch inputs and synchronous control logic such as the RAM FSM, which advances one step per pulse.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `i_sw`; legal range 2..4.
- `DEBOUNCE_CYCLES`, default 0: consecutive cycles the synchronized level must differ from the accepted level before it is accepted. 0 disables debounce. Legal range 0..65535.
- `EDGE_MODE`, default 0: 0 = rising, 1 = falling, 2 = both edges. Value 3 behaves as 0.
- `clk`, input, 1: single system clock; all flops use its rising edge.
- `i_rst`, input, 1: reset, asynchronous and active-low (0 = in reset).
- `i_sw`, input, 1: raw switch level, asynchronous to `clk`.
- `o_enable`, output, 1: registered pulse, high for exactly one `clk` cycle per qualifying edge.
- `o_level`, output, 1: registered accepted (synchronized, debounced) level.

## Operation
- Datapath order: synchronizer chain, then debounce filter, then accepted level `L`, then delayed copy `L_d`, then registered edge detect into `o_enable`.
- Synchronizer: the first stage samples `i_sw`. The last stage output is `s`. No combinational path exists from `i_sw` to any output.
- Debounce with `DEBOUNCE_CYCLES`=0: `L` <= `s` every cycle.
- Debounce with `DEBOUNCE_CYCLES`=N>0:
  - Counter of width ceil(log2(N+1)).
  - If `s`==`L`: counter is cleared.
  - Otherwise: counter increments. When it reaches N, `L` <= `s` and the counter is cleared in the same cycle.
  - Glitches shorter than N cycles never change `L`.
- `L_d` <= `L` every cycle.
- Edge detect, registered into `o_enable`:
  - Rising: `L & ~L_d`.
  - Falling: `~L & L_d`.
  - Both: `L ^ L_d`.
- `o_level` = `L`.
- Reset (`i_rst`=0), asynchronous: all synchronizer flops, `L`, `L_d`, the counter and `o_enable` clear to 0. `o_enable`=0 and `o_level`=0 while in reset.
- Level high at reset release: if `i_sw` is high when `i_rst` deasserts, the 0-to-1 transition of `L` counts as a rising edge and produces one pulse.
- Reset mid-operation: a pending debounce count or pulse is discarded. No pulse is produced during reset.

## Timing
- Latency, `DEBOUNCE_CYCLES`=0, `SYNC_STAGES`=S: `i_sw` first sampled at the edge at clock edge k. `o_enable` is high from edge k+S through edge k+S+1, i.e. exactly one cycle.
- Latency with debounce N>0: add N cycles.
- `o_level` changes one edge before `o_enable` rises.
- Minimum pulse spacing, `DEBOUNCE_CYCLES`=0: an input level held for at least 1 sampled cycle produces an edge. Toggling every 2 cycles yields one pulse per qualifying edge, each exactly 1 cycle wide, never merged.
- An input held steady produces no further pulses.
- Throughput: one pulse per accepted transition. Back-to-back accepted transitions in `EDGE_MODE`=2 produce consecutive 1-cycle pulses.

## Test plan
- Reset hold: `i_rst`=0 for 2 cycles with `i_sw`=0, then release; `i_sw` stays 0 -> `o_enable`=0 and `o_level`=0 throughout.
- Single rising edge, defaults: `i_sw` 0 to 1 sampled at edge k -> `o_enable`=1 only between edges k+2 and k+3; `o_level`=1 from edge k+1 onward.
- Repeated toggling, defaults, 20 ns clock: release reset at 40 ns; `i_sw` toggles every 40 ns (1, 0, 1, 0, 1) -> exactly 3 one-cycle pulses, each 2 cycles after its rising sample; none on falling edges.
- `EDGE_MODE`=2 with the same toggling -> 5 one-cycle pulses.
- Debounce, `DEBOUNCE_CYCLES`=4:
  - 3-cycle high glitch -> no pulse and `o_level` stays 0.
  - Level held 10 cycles -> one pulse, 4 cycles later than with defaults.
- Async reset mid-pulse: assert `i_rst`=0 while `o_enable`=1 -> `o_enable` drops immediately, before the next clock edge. After release with `i_sw`=1 -> exactly one new pulse.
